// File: rtl/lcd_score_announcer_pkg.sv
// Shared encodings, FSM states, ASCII constants and message text for lcd_score_announcer.
package lcd_score_announcer_pkg;

  localparam int unsigned DefCharGap = 4;
  localparam int unsigned DefMsgLen  = 16;

  localparam logic [1:0] StatusTied    = 2'b00;
  localparam logic [1:0] StatusP1Leads = 2'b01;
  localparam logic [1:0] StatusP2Leads = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGap,
    StWrite,
    StDone
  } state_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiOne   = 8'h31;
  localparam logic [7:0] AsciiTwo   = 8'h32;
  localparam logic [7:0] AsciiColon = 8'h3a;

  localparam logic [127:0] TxtP1   = "Player 1 winning";
  localparam logic [127:0] TxtP2   = "Player 2 winning";
  localparam logic [127:0] TxtTied = "Score is tied!  ";

  // Positions past the 16-character text pad with spaces.
  function automatic logic [7:0] line1_char(input logic [1:0] st, input int unsigned idx);
    logic [127:0] txt;
    logic [6:0]   base;
    case (st)
      StatusP1Leads: txt = TxtP1;
      StatusP2Leads: txt = TxtP2;
      default:       txt = TxtTied;
    endcase
    if (idx >= 16) return AsciiSpace;
    base = 7'(8 * (15 - idx));
    return txt[base +: 8];
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return AsciiZero + {4'b0000, d};
  endfunction

endpackage

// File: rtl/lcd_score_announcer_bin2bcd.sv
// score_bin2bcd: 10-bit score to three decimal digits, clamped at 999.
// Only built when LCD_SCORE_DIGITS_EN is defined.
`ifdef LCD_SCORE_DIGITS_EN
module score_bin2bcd (
  input  logic [9:0] i_bin,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [9:0] w_val;

  assign w_val      = (i_bin > 10'd999) ? 10'd999 : i_bin;
  assign o_hundreds = 4'(w_val / 10'd100);
  assign o_tens     = 4'((w_val / 10'd10) % 10'd10);
  assign o_ones     = 4'(w_val % 10'd10);

endmodule
`endif

// File: rtl/lcd_score_announcer.sv
// Announces the leading player on a character LCD: clear strobe, then one write per character.
// Optional LCD_SCORE_DIGITS_EN adds a second line with both scores in decimal.
module lcd_score_announcer
  import lcd_score_announcer_pkg::*;
#(
  parameter int unsigned CHAR_GAP = DefCharGap,
  parameter int unsigned MSG_LEN  = DefMsgLen
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] player1_score,
  input  logic [9:0] player2_score,
  input  logic       lcd_ready,
  output logic       lcd_clear,
  output logic       lcd_write_en,
  output logic [7:0] lcd_write_data,
  output logic       busy,
  output logic [1:0] status
);

`ifdef LCD_SCORE_DIGITS_EN
  localparam int unsigned TotalLen = 2 * MSG_LEN;
`else
  localparam int unsigned TotalLen = MSG_LEN;
`endif
  localparam int unsigned IdxW = $clog2(TotalLen + 1);
  localparam int unsigned GapW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = (CHAR_GAP == 0) ? '0 : GapW'(CHAR_GAP - 1);

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic [GapW-1:0] r_gap;
  logic [1:0]      r_snap_status;
  logic [1:0]      r_announced;
  logic            r_announced_valid;
  logic [1:0]      w_status;
  logic            w_start;
  logic            w_last;
  logic [7:0]      w_char;

  always_comb begin
    w_status = StatusTied;
    if (player1_score > player2_score)      w_status = StatusP1Leads;
    else if (player2_score > player1_score) w_status = StatusP2Leads;
  end

`ifdef LCD_SCORE_DIGITS_EN
  logic [9:0]  r_snap_p1, r_snap_p2, r_ann_p1, r_ann_p2;
  logic [3:0]  w_p1_h, w_p1_t, w_p1_o, w_p2_h, w_p2_t, w_p2_o;
  logic [7:0]  w_line2;
  int unsigned w_pos;

  score_bin2bcd u_bcd_p1 (
    .i_bin      (r_snap_p1),
    .o_hundreds (w_p1_h),
    .o_tens     (w_p1_t),
    .o_ones     (w_p1_o)
  );

  score_bin2bcd u_bcd_p2 (
    .i_bin      (r_snap_p2),
    .o_hundreds (w_p2_h),
    .o_tens     (w_p2_t),
    .o_ones     (w_p2_o)
  );

  // Line 2 layout: "1:ddd     2:ddd "
  always_comb begin
    w_pos   = 32'(r_idx) - MSG_LEN;
    w_line2 = AsciiSpace;
    case (w_pos)
      0:  w_line2 = AsciiOne;
      1:  w_line2 = AsciiColon;
      2:  w_line2 = ascii_digit(w_p1_h);
      3:  w_line2 = ascii_digit(w_p1_t);
      4:  w_line2 = ascii_digit(w_p1_o);
      10: w_line2 = AsciiTwo;
      11: w_line2 = AsciiColon;
      12: w_line2 = ascii_digit(w_p2_h);
      13: w_line2 = ascii_digit(w_p2_t);
      14: w_line2 = ascii_digit(w_p2_o);
      default: w_line2 = AsciiSpace;
    endcase
  end
`endif

  always_comb begin
    w_start = !r_announced_valid || (w_status != r_announced);
`ifdef LCD_SCORE_DIGITS_EN
    w_start = w_start || (player1_score != r_ann_p1) || (player2_score != r_ann_p2);
`endif
    w_char = line1_char(r_snap_status, 32'(r_idx));
`ifdef LCD_SCORE_DIGITS_EN
    if (32'(r_idx) >= MSG_LEN) w_char = w_line2;
`endif
  end

  assign w_last = (32'(r_idx) == TotalLen - 1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state           <= StIdle;
      r_idx             <= '0;
      r_gap             <= '0;
      r_snap_status     <= StatusTied;
      r_announced       <= StatusTied;
      r_announced_valid <= 1'b0;
`ifdef LCD_SCORE_DIGITS_EN
      r_snap_p1         <= '0;
      r_snap_p2         <= '0;
      r_ann_p1          <= '0;
      r_ann_p2          <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_snap_status <= w_status;
`ifdef LCD_SCORE_DIGITS_EN
            r_snap_p1     <= player1_score;
            r_snap_p2     <= player2_score;
`endif
            r_idx         <= '0;
            r_state       <= StClear;
          end
        end
        StClear: begin
          if (lcd_ready) begin
            r_gap   <= GapLoad;
            r_state <= (CHAR_GAP == 0) ? StWrite : StGap;
          end
        end
        StGap: begin
          // r_idx already points past the last character once the message is out.
          if (r_gap == '0) r_state <= (32'(r_idx) == TotalLen) ? StDone : StWrite;
          else             r_gap   <= r_gap - 1'b1;
        end
        StWrite: begin
          if (lcd_ready) begin
            r_idx <= r_idx + 1'b1;
            r_gap <= GapLoad;
            if (CHAR_GAP != 0) r_state <= StGap;
            else if (w_last)   r_state <= StDone;
          end
        end
        StDone: begin
          r_announced       <= r_snap_status;
          r_announced_valid <= 1'b1;
`ifdef LCD_SCORE_DIGITS_EN
          r_ann_p1          <= r_snap_p1;
          r_ann_p2          <= r_snap_p2;
`endif
          r_state           <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Strobes qualify on lcd_ready in the same cycle so a not-ready LCD never sees one.
  assign lcd_clear      = (r_state == StClear) && lcd_ready;
  assign lcd_write_en   = (r_state == StWrite) && lcd_ready;
  assign lcd_write_data = lcd_write_en ? w_char : 8'h00;
  assign busy           = (r_state != StIdle);
  assign status         = w_status;

endmodule

// File: doc/lcd_score_announcer.md
LCD_SCORE_ANNOUNCER -- requirements
Module: lcd_score_announcer

Interface
REQ-001 SHALL have parameter CHAR_GAP, default 4: minimum idle cycles between successive LCD strobes.
REQ-002 SHALL have parameter MSG_LEN, default 16: characters per text line.
REQ-003 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port player1_score, input, 10: unsigned player-1 score.
REQ-006 SHALL have port player2_score, input, 10: unsigned player-2 score.
REQ-007 SHALL have port lcd_ready, input, 1: LCD controller can accept a strobe.
REQ-008 SHALL have port lcd_clear, output, 1: one-cycle clear-display strobe.
REQ-009 SHALL have port lcd_write_en, output, 1: one-cycle character-write strobe.
REQ-010 SHALL have port lcd_write_data, output, 8: ASCII character, valid only while lcd_write_en=1.
REQ-011 SHALL have port busy, output, 1: high while a message is being sequenced.
REQ-012 SHALL have port status, output, 2: 00 tied, 01 player 1 leads, 10 player 2 leads.

Function
REQ-013 SHALL compute status combinationally from unsigned comparison of player1_score and player2_score each cycle.
REQ-014 SHALL use FSM states IDLE, CLEAR, GAP, WRITE, DONE.
REQ-015 SHALL start a message from IDLE when status differs from the last announced status, or on the first cycle after reset.
REQ-016 SHALL latch status and both scores into a snapshot at message start; later input changes do not affect that message.
REQ-017 In CLEAR, SHALL pulse lcd_clear for exactly one cycle, in the first cycle lcd_ready=1, then enter GAP.
REQ-018 In WRITE, SHALL pulse lcd_write_en for exactly one cycle per character, only when lcd_ready=1; with lcd_ready=0 the FSM holds and no strobe is issued.
REQ-019 GAP SHALL last exactly CHAR_GAP cycles after each strobe before the next strobe is allowed.
REQ-020 Text SHALL be "Player 1 winning" for 01, "Player 2 winning" for 10, and "Score is tied!" padded with spaces to MSG_LEN for 00.
REQ-021 After the last character, SHALL enter DONE for one cycle, record the snapshot status as announced, and return to IDLE.
REQ-022 If status changes during a message, SHALL finish the current message uninterrupted, then start a new message from IDLE.
REQ-023 lcd_clear and lcd_write_en SHALL never be high in the same cycle.
REQ-024 busy SHALL be high in every state except IDLE.

Reset
REQ-025 On resetn=0, SHALL immediately force state IDLE, lcd_clear=0, lcd_write_en=0, lcd_write_data=8'h00 and busy=0, and clear the character index and gap counter, including during a message.
REQ-026 After reset release, SHALL treat the announced status as invalid, so that one message is always produced.

Configuration
REQ-027 Macro LCD_SCORE_DIGITS_EN: when defined, SHALL append a second MSG_LEN line "1:ddd     2:ddd " after line 1.
REQ-028 In that line, ddd is the 3-digit zero-padded decimal of the snapshot score, clamped to 999.
REQ-029 With LCD_SCORE_DIGITS_EN, any change in either score SHALL also start a new message.
REQ-030 When LCD_SCORE_DIGITS_EN is undefined, SHALL emit only line 1 and instantiate no decimal logic.

Structure
REQ-031 The shared package SHALL hold the status encodings, FSM state enum, ASCII constants and default CHAR_GAP/MSG_LEN.
REQ-032 Under LCD_SCORE_DIGITS_EN, binary-to-decimal conversion SHALL be the sub-module score_bin2bcd: 10-bit in, three 4-bit digits out, clamped at 999.

Verification
REQ-033 Reset release, scores 0/0, lcd_ready=1 -> one lcd_clear, then 16 writes "Score is tied!  ", spaced CHAR_GAP+1 cycles, then busy=0.
REQ-034 Scores 5/3 after the tied message -> status=01, clear, then "Player 1 winning".
REQ-035 Scores change 5/3 to 3/9 in mid-message -> the "Player 1 winning" message completes, then a "Player 2 winning" message follows.
REQ-036 lcd_ready held at 0 for 20 cycles mid-message -> no strobes, index held, resumes at the correct character.
REQ-037 resetn asserted at character 7 -> all outputs 0 in the same cycle; after release, a full message restarts from clear.
REQ-038 With LCD_SCORE_DIGITS_EN, scores 1023/42 -> line 2 "1:999     2:042 "; score 42 to 43 with status unchanged -> new message sequenced.
